// File: rtl/al_accel_wbuf_loader_if.sv
// al_accel_wbuf_loader_if: weight stream input and weight buffer load port bundle
interface al_accel_wbuf_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic [31:0] wbuf_di;
  logic [1:0]  wbuf_wstrb;
  logic        wbuf_ld_wrn;
  modport master (
    output in_valid, in_data, in_nbytes,
    input  in_ready, wbuf_di, wbuf_wstrb, wbuf_ld_wrn
  );
  modport slave (
    input  in_valid, in_data, in_nbytes,
    output in_ready, wbuf_di, wbuf_wstrb, wbuf_ld_wrn
  );
endinterface

// File: rtl/al_accel_wbuf_loader.sv
// al_accel_wbuf_loader: FIFO-buffered weight stream feeder for the al_accel_wbuf load port
module al_accel_wbuf_loader #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enb,
  input  logic                 start,
  input  logic [CNT_W-1:0]     cfg_nweights,
  al_accel_wbuf_loader_if.slave bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CNT_W-1:0]     loaded_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] nw_q, rem;
  logic [31:0] mem_d [DEPTH];
  logic [2:0] mem_n [DEPTH];
  logic [AW:0] wp, rp;
  logic [2:0] head_n, eff;
  logic full, empty, term, acc, bad, push, pop, flush;
  assign full = (wp - rp) == (AW+1)'(DEPTH);
  assign empty = wp == rp;
  assign term = loaded_cnt == nw_q;
  assign bus.in_ready = state_q == LOAD && !full && !term;
  assign acc = bus.in_valid && bus.in_ready;
  assign bad = acc && (bus.in_nbytes == 3'd0 || bus.in_nbytes > 3'd4);
  assign push = acc && !bad;
  assign pop = state_q == LOAD && enb && !empty && !term && !start;
  assign flush = start || (state_q == LOAD && term);
  assign head_n = mem_n[rp[AW-1:0]];
  assign rem = nw_q - loaded_cnt;
  assign eff = (CNT_W'(head_n) > rem) ? rem[2:0] : head_n;
  assign busy = state_q == LOAD;
  assign done = state_q == DONE;
  // Next state: start restarts from anywhere; reaching the byte total ends the load
  always_comb begin
    state_d = start ? (cfg_nweights == '0 ? DONE : LOAD) : (state_q == LOAD && term) ? DONE : state_q;
  end
  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  // FIFO pointers, cleared on restart and when the load completes
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  end
  // FIFO storage: word plus its byte count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wp[AW-1:0]] <= bus.in_data;
      mem_n[wp[AW-1:0]] <= bus.in_nbytes;
    end
  end
  // Load port, byte counter and sticky error; the final word is clipped to the remaining bytes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.wbuf_di <= '0;
      bus.wbuf_wstrb <= '0;
      bus.wbuf_ld_wrn <= 1'b0;
      loaded_cnt <= '0;
      nw_q <= '0;
      err <= 1'b0;
    end else begin
      bus.wbuf_ld_wrn <= pop;
      if (pop) begin
        bus.wbuf_di <= mem_d[rp[AW-1:0]];
        bus.wbuf_wstrb <= 2'(eff - 3'd1);
      end
      nw_q <= start ? cfg_nweights : nw_q;
      loaded_cnt <= start ? '0 : pop ? loaded_cnt + CNT_W'(eff) : loaded_cnt;
      err <= !start && (err || bad);
    end
  end
endmodule

// File: tb/tb_al_accel_wbuf_loader.sv
// tb_al_accel_wbuf_loader: scoreboard bench with a byte-budget reference model
module tb_al_accel_wbuf_loader;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  logic clk = 1'b0, resetn = 1'b0, enb = 1'b0, start = 1'b0;
  logic [CNT_W-1:0] cfg_nweights = '0;
  logic busy, done, err;
  logic [CNT_W-1:0] loaded_cnt;
  al_accel_wbuf_loader_if bus();
  al_accel_wbuf_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .enb(enb), .start(start), .cfg_nweights(cfg_nweights),
    .bus(bus), .busy(busy), .done(done), .err(err), .loaded_cnt(loaded_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic [1:0] s; int cnt;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int st_q[$];
  int checks = 0, failures = 0, rem_m = 0, loaded_m = 0, cyc = 0, accepts = 0;
  bit err_m = 0, stop = 0, drv_busy = 0, ok;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  task automatic model_start(input int c);
    exp_q.delete();
    rem_m = c;
    loaded_m = 0;
    err_m = 0;
  endtask
  task automatic model_accept(input logic [31:0] d, input logic [2:0] nb);
    int e;
    exp_t x;
    if (nb == 0 || nb > 4) err_m = 1;
    else if (rem_m > 0) begin
      e = (int'(nb) < rem_m) ? int'(nb) : rem_m;
      rem_m -= e;
      loaded_m += e;
      x.d = d;
      x.s = 2'(e - 1);
      x.cnt = loaded_m;
      exp_q.push_back(x);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic [2:0] nb, input int lim, input bit must, output bit acc);
    logic r;
    bus.in_data = d;
    bus.in_nbytes = nb;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < lim && !acc && !stop; i++) begin
      r = bus.in_ready;
      @(posedge clk);
      if (r && resetn && !start) begin
        acc = 1;
        accepts++;
        model_accept(d, nb);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (must && !stop) chk("send_accepted", acc, 1);
  endtask
  task automatic drive_words(input int n, input logic [31:0] base);
    bit a;
    drv_busy = 1;
    for (int k = 0; k < n && !stop; k++) send(base + 32'(k), 3'd4, 300, 1, a);
    drv_busy = 0;
  endtask
  task automatic do_start(input int c);
    start = 1'b1;
    cfg_nweights = CNT_W'(c);
    @(posedge clk);
    model_start(c);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done !== 1'b1; i++) @(negedge clk);
    chk("done_reached", done, 1);
  endtask
  task automatic wait_drv();
    for (int i = 0; i < 400 && drv_busy; i++) @(negedge clk);
    chk("driver_idle", drv_busy, 0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_di"}, bus.wbuf_di, 0);
    chk({tag, "_wstrb"}, bus.wbuf_wstrb, 0);
    chk({tag, "_ld_wrn"}, bus.wbuf_ld_wrn, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cnt"}, loaded_cnt, 0);
  endtask
  // Cycle counter used to timestamp load strobes
  always @(posedge clk) cyc++;
  // Monitor: every load strobe must match the oldest expected load
  always @(negedge clk) begin
    chk("busy_done_exclusive", busy && done, 0);
    if (bus.wbuf_ld_wrn === 1'b1) begin
      st_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: di=%h wstrb=%0d cnt=%0d but no load expected", bus.wbuf_di, bus.wbuf_wstrb, loaded_cnt);
      end else begin
        mon_e = exp_q.pop_front();
        chk("load_di", bus.wbuf_di, mon_e.d);
        chk("load_wstrb", bus.wbuf_wstrb, mon_e.s);
        chk("load_cnt", loaded_cnt, mon_e.cnt);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end
  initial begin
    int c;
    logic [2:0] nb;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_nbytes = '0;
    start = 1'b1;
    cfg_nweights = 16'd8;
    cycles(3);
    start = 1'b0;
    chk_reset_vals("reset");
    resetn = 1'b1;
    cycles(2);
    chk("start_in_reset_ignored", busy, 0);
    chk("idle_in_ready", bus.in_ready, 0);
    do_start(8);
    chk("in_ready_after_start", bus.in_ready, 1);
    enb = 1'b1;
    send(32'h5876063e, 3'd4, 50, 1, ok);
    chk("ld_not_yet", bus.wbuf_ld_wrn, 0);
    @(negedge clk);
    chk("ld_latency", bus.wbuf_ld_wrn, 1);
    send(32'haabb7788, 3'd4, 50, 1, ok);
    wait_done(50);
    chk("basic_cnt", loaded_cnt, 8);
    chk("basic_in_ready", bus.in_ready, 0);
    chk("basic_busy", busy, 0);
    chk("basic_wstrb_hold", bus.wbuf_wstrb, 3);
    chk("basic_di_hold", bus.wbuf_di, 32'haabb7788);
    do_start(6);
    send(32'h11223344, 3'd4, 50, 1, ok);
    send(32'h55667788, 3'd4, 50, 1, ok);
    wait_done(50);
    chk("clip_cnt", loaded_cnt, 6);
    chk("clip_wstrb", bus.wbuf_wstrb, 1);
    send(32'h99aabbcc, 3'd4, 6, 0, ok);
    chk("clip_third_refused", ok, 0);
    do_start(20);
    enb = 1'b0;
    st_q.delete();
    accepts = 0;
    fork
      drive_words(5, 32'hb0b00000);
    join_none
    cycles(12);
    chk("bp_accepts", accepts, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_no_strobe", st_q.size(), 0);
    enb = 1'b1;
    wait_done(100);
    wait_drv();
    chk("bp_strobes", st_q.size(), 5);
    if (st_q.size() >= 4) for (int k = 0; k < 3; k++) chk("bp_consecutive", st_q[k+1] - st_q[k], 1);
    chk("bp_fifth_accepted", accepts, 5);
    chk("bp_cnt", loaded_cnt, 20);
    do_start(8);
    st_q.delete();
    send(32'hdead0000, 3'd0, 20, 1, ok);
    send(32'hdead0005, 3'd5, 20, 1, ok);
    cycles(4);
    chk("err_set", err, err_m);
    chk("err_cnt", loaded_cnt, 0);
    chk("err_no_load", st_q.size(), 0);
    do_start(4);
    chk("err_cleared", err, 0);
    send(32'h0badf00d, 3'd4, 50, 1, ok);
    wait_done(50);
    chk("err_after_cnt", loaded_cnt, 4);
    do_start(16);
    enb = 1'b0;
    st_q.delete();
    send(32'hab000001, 3'd4, 50, 1, ok);
    send(32'hab000002, 3'd4, 50, 1, ok);
    cycles(2);
    do_start(8);
    chk("abort_cnt", loaded_cnt, 0);
    enb = 1'b1;
    cycles(4);
    chk("abort_no_load", st_q.size(), 0);
    chk("abort_busy", busy, 1);
    send(32'hcd000001, 3'd4, 50, 1, ok);
    send(32'hcd000002, 3'd4, 50, 1, ok);
    wait_done(50);
    chk("abort_after_cnt", loaded_cnt, 8);
    chk("abort_after_strobes", st_q.size(), 2);
    do_start(40);
    st_q.delete();
    fork
      drive_words(10, 32'hc0c00000);
    join_none
    for (int i = 0; i < 100 && st_q.size() < 3; i++) @(negedge clk);
    chk("reset_mid_load_active", st_q.size() >= 3, 1);
    #1;
    resetn = 1'b0;
    stop = 1;
    model_start(0);
    @(negedge clk);
    chk_reset_vals("midreset");
    resetn = 1'b1;
    wait_drv();
    stop = 0;
    cycles(4);
    chk("reset_idle_busy", busy, 0);
    chk("reset_idle_done", done, 0);
    chk("reset_idle_in_ready", bus.in_ready, 0);
    for (int t = 0; t < 12; t++) begin
      c = $urandom_range(1, 30);
      do_start(c);
      for (int g = 0; g < 200 && done !== 1'b1; g++) begin
        enb = ($urandom_range(0, 3) != 0);
        nb = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
        send($urandom, nb, 4, 0, ok);
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      enb = 1'b1;
      wait_done(200);
      chk("rand_cnt", loaded_cnt, c);
      chk("rand_err", err, err_m);
      chk("rand_drained", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
